// File: rtl/coin_sched.sv
// Shift-enable controller and round-robin arbiter for the shared LFSR coin generator.
// Each hand-out is separated by REFRESH enabled shifts, so consumers never share coin bits.
module coin_sched #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 256,
  parameter int REFRESH = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] lfsr_coins,
  output logic             lfsr_en,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic [WIDTH-1:0] coins_out,
  output logic             ready
);

  localparam int CW = $clog2(REFRESH);
  localparam int PW = $clog2(NREQ);

  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(NREQ - 1);

  localparam logic [1:0] S_WARMUP = 2'd0;
  localparam logic [1:0] S_READY  = 2'd1;
  localparam logic [1:0] S_REFILL = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [WIDTH-1:0] coins_q, coins_d;

  logic             win_vld;
  logic [PW-1:0]    win_idx;

  // Requester index i slots after ptr, wrapping explicitly for non-power-of-2 NREQ.
  function automatic logic [PW-1:0] slot(
    input logic [PW-1:0] ptr,
    input int            i
  );
    int j;
    j = int'(ptr) + i;
    if (j >= NREQ) j = j - NREQ;
    return PW'(j);
  endfunction

  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!win_vld && req[slot(rr_ptr_q, i)]) begin
        win_vld = 1'b1;
        win_idx = slot(rr_ptr_q, i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = '0;
    coins_d  = coins_q;
    case (state_q)
      S_WARMUP, S_REFILL: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_READY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_READY: begin
        if (win_vld) begin
          coins_d        = lfsr_coins;
          gnt_d[win_idx] = 1'b1;
          rr_ptr_d       = (win_idx == PTR_LAST) ? '0 : win_idx + 1'b1;
          cnt_d          = '0;
          state_d        = S_REFILL;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_WARMUP;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_WARMUP;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      coins_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      coins_q  <= coins_d;
    end
  end

  assign lfsr_en   = !rst && (state_q != S_READY);
  assign ready     = !rst && (state_q == S_READY);
  assign gnt       = gnt_q;
  assign coins_out = coins_q;

endmodule
